// File: rtl/avmm_bridge_pkg.sv
// Shared types and defaults for the JTAG-master to CSR-window Avalon-MM bridge.
package avmm_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_RD_RESP = 2'd3
   } bridge_state_t;

   localparam int MAX_TGT = 16;
   localparam int MAX_DW  = 64;

   localparam logic [31:0] DEF_ERR_DATA     = 32'hDEAD_BEEF;
   localparam logic [31:0] DEF_SCRATCH_ADDR = 32'h5000_0030;
   localparam logic [63:0] DEF_BASE_MAP     = {16'h5003, 16'h5002, 16'h5001, 16'h5000};

   // Callers zero-extend the packed read bus to MAX_TGT*MAX_DW and keep the low dw bits.
   function automatic logic [MAX_DW-1:0] rd_slice(input logic [MAX_TGT*MAX_DW-1:0] bus,
                                                  input int unsigned idx,
                                                  input int unsigned dw);
      return MAX_DW'(bus >> (idx * dw));
   endfunction

endpackage

// File: rtl/avmm_win_decode.sv
// Priority address decoder: scratch register first, then lowest-index matching window tag.
module avmm_win_decode
   import avmm_bridge_pkg::*;
#(
   parameter int                             AW           = 32,
   parameter int                             LAW          = 16,
   parameter int                             NUM_TGT      = 4,
   parameter logic [NUM_TGT*(AW-LAW)-1:0]    BASE_MAP     = DEF_BASE_MAP,
   parameter logic [AW-1:0]                  SCRATCH_ADDR = DEF_SCRATCH_ADDR
) (
   input  logic [AW-1:0]      addr,
   output logic               scratch_hit,
   output logic [NUM_TGT-1:0] tgt_onehot,
   output logic [3:0]         tgt_idx,
   output logic               miss
);

   localparam int TW = AW - LAW;

   logic [NUM_TGT-1:0] tag_hit;
   logic [NUM_TGT:0]   hit_below;
   logic [3:0]         idx_acc [NUM_TGT+1];

   assign scratch_hit  = (addr == SCRATCH_ADDR);
   assign hit_below[0] = 1'b0;
   assign idx_acc[0]   = 4'd0;

   generate
      for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_win
         assign tag_hit[gi]     = (addr[AW-1:LAW] == BASE_MAP[gi*TW +: TW]);
         assign hit_below[gi+1] = hit_below[gi] | tag_hit[gi];
         // A lower-index match masks this one, and a scratch hit masks all windows.
         assign tgt_onehot[gi]  = tag_hit[gi] & ~hit_below[gi] & ~scratch_hit;
         assign idx_acc[gi+1]   = idx_acc[gi] | (tgt_onehot[gi] ? 4'(gi) : 4'd0);
      end
   endgenerate

   assign tgt_idx = idx_acc[NUM_TGT];
   assign miss    = ~scratch_hit & ~(|tag_hit);

endmodule

// File: rtl/avmm_csr_xbar_bridge.sv
// Avalon-MM slave fanning one master out to NUM_TGT CSR windows plus a local scratch register.
module avmm_csr_xbar_bridge
   import avmm_bridge_pkg::*;
#(
   parameter int                             AW           = 32,
   parameter int                             DW           = 32,
   parameter int                             LAW          = 16,
   parameter int                             NUM_TGT      = 4,
   parameter logic [NUM_TGT*(AW-LAW)-1:0]    BASE_MAP     = DEF_BASE_MAP,
   parameter logic [AW-1:0]                  SCRATCH_ADDR = DEF_SCRATCH_ADDR,
   parameter int                             TIMEOUT      = 256,
   parameter logic [DW-1:0]                  ERR_DATA     = DEF_ERR_DATA
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AW-1:0]         m_address,
   input  logic                  m_read,
   input  logic                  m_write,
   input  logic [DW-1:0]         m_writedata,
   input  logic [DW/8-1:0]       m_byteenable,
   output logic [DW-1:0]         m_readdata,
   output logic                  m_readdatavalid,
   output logic                  m_waitrequest,
   output logic [LAW-1:0]        t_addr,
   output logic [DW-1:0]         t_wr_data,
   output logic [DW/8-1:0]       t_byteenable,
   output logic [NUM_TGT-1:0]    t_wr_en,
   output logic [NUM_TGT-1:0]    t_rd_en,
   input  logic [NUM_TGT*DW-1:0] t_rd_data,
   input  logic [NUM_TGT-1:0]    t_rd_dvalid,
   output logic [7:0]            err_cnt
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int NB    = DW / 8;

   bridge_state_t        state_reg;
   logic [AW-1:0]        addr_reg;
   logic [DW-1:0]        wdata_reg;
   logic [NB-1:0]        be_reg;
   logic                 is_write_reg;
   logic [DW-1:0]        rdata_reg;
   logic                 rdvalid_reg;
   logic                 waitreq_reg;
   logic [CNT_W-1:0]     wait_cnt_reg;
   logic [7:0]           err_cnt_reg;
   logic [DW-1:0]        scratch_reg;
   logic [DW-1:0]        scratch_next;

   logic                 scratch_hit;
   logic                 miss;
   logic [NUM_TGT-1:0]   tgt_onehot;
   logic [3:0]           tgt_idx;

   logic                 in_issue;
   logic                 drive_cmd;
   logic                 hit_dvalid;
   logic                 wait_expired;
   logic                 err_evt;
   logic                 scratch_wr;
   logic [DW-1:0]        tgt_rdata;
   logic [MAX_TGT*MAX_DW-1:0] rd_bus_wide;

   avmm_win_decode #(
      .AW           (AW),
      .LAW          (LAW),
      .NUM_TGT      (NUM_TGT),
      .BASE_MAP     (BASE_MAP),
      .SCRATCH_ADDR (SCRATCH_ADDR)
   ) u_decode (
      .addr        (addr_reg),
      .scratch_hit (scratch_hit),
      .tgt_onehot  (tgt_onehot),
      .tgt_idx     (tgt_idx),
      .miss        (miss)
   );

   always_comb begin
      rd_bus_wide                   = '0;
      rd_bus_wide[NUM_TGT*DW-1:0]   = t_rd_data;
   end

   assign tgt_rdata    = DW'(rd_slice(rd_bus_wide, 32'(tgt_idx), $unsigned(DW)));
   assign in_issue     = (state_reg == ST_ISSUE);
   assign drive_cmd    = in_issue || (state_reg == ST_RD_WAIT);
   // Only the selected target's valid counts; stray or late strobes from others are ignored.
   assign hit_dvalid   = |(t_rd_dvalid & tgt_onehot);
   assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT - 2));
   assign err_evt      = (in_issue && miss) ||
                         ((state_reg == ST_RD_WAIT) && !hit_dvalid && wait_expired);
   assign scratch_wr   = in_issue && is_write_reg && scratch_hit;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_scratch_byte
         assign scratch_next[gi*8 +: 8] = (scratch_wr && be_reg[gi]) ?
                                          wdata_reg[gi*8 +: 8] : scratch_reg[gi*8 +: 8];
      end
   endgenerate

   assign t_addr          = drive_cmd ? addr_reg[LAW-1:0] : '0;
   assign t_wr_data       = drive_cmd ? wdata_reg : '0;
   assign t_byteenable    = drive_cmd ? be_reg : '0;
   assign t_wr_en         = (in_issue &&  is_write_reg) ? tgt_onehot : '0;
   assign t_rd_en         = (in_issue && !is_write_reg) ? tgt_onehot : '0;
   assign m_readdata      = rdata_reg;
   assign m_readdatavalid = rdvalid_reg;
   assign m_waitrequest   = waitreq_reg;
   assign err_cnt         = err_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         be_reg       <= '0;
         is_write_reg <= 1'b0;
         rdata_reg    <= '0;
         rdvalid_reg  <= 1'b0;
         waitreq_reg  <= 1'b1;
         wait_cnt_reg <= '0;
      end else begin
         rdvalid_reg <= 1'b0;
         rdata_reg   <= '0;
         case (state_reg)
            ST_IDLE: begin
               waitreq_reg <= 1'b0;
               // The post-reset cycle still shows waitrequest, so nothing is accepted there.
               if (!waitreq_reg && (m_read || m_write)) begin
                  addr_reg     <= m_address;
                  wdata_reg    <= m_writedata;
                  be_reg       <= m_byteenable;
                  is_write_reg <= m_write;
                  waitreq_reg  <= 1'b1;
                  state_reg    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wait_cnt_reg <= '0;
               if (is_write_reg) begin
                  waitreq_reg <= 1'b0;
                  state_reg   <= ST_IDLE;
               end else if (scratch_hit) begin
                  rdata_reg   <= scratch_reg;
                  rdvalid_reg <= 1'b1;
                  state_reg   <= ST_RD_RESP;
               end else if (miss) begin
                  rdata_reg   <= ERR_DATA;
                  rdvalid_reg <= 1'b1;
                  state_reg   <= ST_RD_RESP;
               end else begin
                  state_reg <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (hit_dvalid) begin
                  rdata_reg   <= tgt_rdata;
                  rdvalid_reg <= 1'b1;
                  state_reg   <= ST_RD_RESP;
               end else if (wait_expired) begin
                  rdata_reg   <= ERR_DATA;
                  rdvalid_reg <= 1'b1;
                  state_reg   <= ST_RD_RESP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            default: begin
               waitreq_reg <= 1'b0;
               state_reg   <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch_reg <= '0;
         err_cnt_reg <= '0;
      end else begin
         scratch_reg <= scratch_next;
         if (err_evt && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_avmm_csr_xbar_bridge.sv
// Directed scoreboard bench: stimulus pushes expected target strobes and read responses, monitors pop and compare.
module tb_avmm_csr_xbar_bridge;

   localparam logic [31:0] ERR_D   = 32'hDEAD_BEEF;
   localparam logic [31:0] SCR_A   = 32'h5000_0030;
   localparam int          TMO     = 256;

   logic          clk;
   logic          rst_n;
   logic [31:0]   m_address;
   logic          m_read;
   logic          m_write;
   logic [31:0]   m_writedata;
   logic [3:0]    m_byteenable;
   logic [31:0]   m_readdata;
   logic          m_readdatavalid;
   logic          m_waitrequest;
   logic [15:0]   t_addr;
   logic [31:0]   t_wr_data;
   logic [3:0]    t_byteenable;
   logic [3:0]    t_wr_en;
   logic [3:0]    t_rd_en;
   logic [127:0]  t_rd_data;
   logic [3:0]    t_rd_dvalid;
   logic [7:0]    err_cnt;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } rd_exp_t;

   typedef struct {
      logic [3:0]  en;
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          cyc;
   } strobe_exp_t;

   rd_exp_t     rd_q[$];
   strobe_exp_t wr_q[$];
   strobe_exp_t rden_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   avmm_csr_xbar_bridge dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_byteenable    (m_byteenable),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .m_waitrequest   (m_waitrequest),
      .t_addr          (t_addr),
      .t_wr_data       (t_wr_data),
      .t_byteenable    (t_byteenable),
      .t_wr_en         (t_wr_en),
      .t_rd_en         (t_rd_en),
      .t_rd_data       (t_rd_data),
      .t_rd_dvalid     (t_rd_dvalid),
      .err_cnt         (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: bound expired, required completion (cycle %0d)", name, cyc);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present a command and hold it until the bridge accepts; returns the acceptance cycle.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, output int acc);
      acc          = -1;
      m_address    = addr;
      m_writedata  = data;
      m_byteenable = be;
      m_write      = wr;
      m_read       = ~wr;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!m_waitrequest) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) bound_fail("accept");
      step();
      m_read  = 1'b0;
      m_write = 1'b0;
   endtask

   task automatic wait_idle;
      int k;
      for (k = 0; k < 400; k++) begin
         if (!m_waitrequest) break;
         step();
      end
      if (k == 400) bound_fail("wait_idle");
   endtask

   // Read response monitor
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk);
         if (m_readdatavalid) begin
            if (rd_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_rdvalid: got data %h, required no response (cycle %0d)", m_readdata, cyc);
            end else begin
               e = rd_q.pop_front();
               $display("rd resp   cycle=%0d data=%h", cyc, m_readdata);
               chk("rd_data", 64'(m_readdata), 64'(e.data));
               chk("rd_cycle", 64'(cyc), 64'(e.cyc));
            end
         end else begin
            chk("rd_data_idle", 64'(m_readdata), 64'd0);
         end
      end
   end

   // Target strobe monitor
   initial begin
      strobe_exp_t e;
      forever begin
         @(negedge clk);
         if (t_wr_en != 4'd0) begin
            if (wr_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_wr_en: got %b, required 0000 (cycle %0d)", t_wr_en, cyc);
            end else begin
               e = wr_q.pop_front();
               $display("tgt write cycle=%0d en=%b addr=%h data=%h be=%h", cyc, t_wr_en, t_addr, t_wr_data, t_byteenable);
               chk("wr_en", 64'(t_wr_en), 64'(e.en));
               chk("wr_addr", 64'(t_addr), 64'(e.addr));
               chk("wr_data", 64'(t_wr_data), 64'(e.data));
               chk("wr_be", 64'(t_byteenable), 64'(e.be));
               chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (t_rd_en != 4'd0) begin
            if (rden_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_rd_en: got %b, required 0000 (cycle %0d)", t_rd_en, cyc);
            end else begin
               e = rden_q.pop_front();
               $display("tgt read  cycle=%0d en=%b addr=%h", cyc, t_rd_en, t_addr);
               chk("rd_en", 64'(t_rd_en), 64'(e.en));
               chk("rd_addr", 64'(t_addr), 64'(e.addr));
               chk("rd_en_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
      end
   end

   initial begin
      int a;
      int k;
      rst_n        = 1'b0;
      m_address    = '0;
      m_read       = 1'b0;
      m_write      = 1'b0;
      m_writedata  = '0;
      m_byteenable = '0;
      t_rd_data    = '0;
      t_rd_dvalid  = '0;
      repeat (3) step();

      chk("rst_waitreq", 64'(m_waitrequest), 64'd1);
      chk("rst_rdvalid", 64'(m_readdatavalid), 64'd0);
      chk("rst_strobes", 64'({t_wr_en, t_rd_en}), 64'd0);
      chk("rst_taddr", 64'(t_addr), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      rst_n = 1'b1;
      step();

      // 1: target 2 write
      wr_q.push_back('{en: 4'b0100, addr: 16'h0010, data: 32'h1234_5678, be: 4'hF, cyc: 0});
      issue(1'b1, 32'h5002_0010, 32'h1234_5678, 4'hF, a);
      wr_q[0].cyc = a + 1;
      step();
      chk("t1_err_cnt", 64'(err_cnt), 64'd0);
      chk("t1_taddr_idle", 64'(t_addr), 64'd0);

      // 2: target 1 read, dvalid three cycles after t_rd_en
      issue(1'b0, 32'h5001_0004, 32'h0, 4'hF, a);
      rden_q.push_back('{en: 4'b0010, addr: 16'h0004, data: 32'h0, be: 4'h0, cyc: a + 1});
      chk("t2_waitreq_issue", 64'(m_waitrequest), 64'd1);
      repeat (3) step();
      t_rd_dvalid        = 4'b0010;
      t_rd_data[32 +: 32] = 32'hCAFE_0001;
      rd_q.push_back('{data: 32'hCAFE_0001, cyc: a + 5});
      chk("t2_waitreq_wait", 64'(m_waitrequest), 64'd1);
      step();
      t_rd_dvalid = 4'b0000;
      wait_idle();

      // 3: scratch byte-enabled write then readback
      issue(1'b1, SCR_A, 32'hAABB_CCDD, 4'b0101, a);
      issue(1'b0, SCR_A, 32'h0, 4'hF, a);
      rd_q.push_back('{data: 32'h00BB_00DD, cyc: a + 2});
      wait_idle();
      chk("t3_err_cnt", 64'(err_cnt), 64'd0);

      // 4: read miss
      issue(1'b0, 32'h6000_0000, 32'h0, 4'hF, a);
      rd_q.push_back('{data: ERR_D, cyc: a + 2});
      wait_idle();
      chk("t4_err_cnt", 64'(err_cnt), 64'd1);

      // 5: target 3 timeout, then target 0 read with stray strobes
      issue(1'b0, 32'h5003_0008, 32'h0, 4'hF, a);
      rden_q.push_back('{en: 4'b1000, addr: 16'h0008, data: 32'h0, be: 4'h0, cyc: a + 1});
      rd_q.push_back('{data: ERR_D, cyc: a + 1 + TMO});
      wait_idle();
      chk("t5_err_cnt", 64'(err_cnt), 64'd2);
      issue(1'b0, 32'h5000_0004, 32'h0, 4'hF, a);
      rden_q.push_back('{en: 4'b0001, addr: 16'h0004, data: 32'h0, be: 4'h0, cyc: a + 1});
      t_rd_dvalid       = 4'b0001;
      t_rd_data[0 +: 32] = 32'h1111_1111;
      step();
      t_rd_dvalid        = 4'b1000;
      t_rd_data[0 +: 32]  = 32'h0;
      t_rd_data[96 +: 32] = 32'h3333_3333;
      step();
      t_rd_dvalid        = 4'b0001;
      t_rd_data[0 +: 32] = 32'hCAFE_0000;
      rd_q.push_back('{data: 32'hCAFE_0000, cyc: a + 4});
      step();
      t_rd_dvalid = 4'b0000;
      wait_idle();
      chk("t5b_err_cnt", 64'(err_cnt), 64'd2);

      // 6: reset while waiting on target 2
      issue(1'b0, 32'h5002_0000, 32'h0, 4'hF, a);
      rden_q.push_back('{en: 4'b0100, addr: 16'h0000, data: 32'h0, be: 4'h0, cyc: a + 1});
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_waitreq", 64'(m_waitrequest), 64'd1);
      chk("t6_rst_strobes", 64'({t_wr_en, t_rd_en}), 64'd0);
      chk("t6_rst_rdvalid", 64'(m_readdatavalid), 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      issue(1'b0, 32'h5001_0008, 32'h0, 4'hF, a);
      rden_q.push_back('{en: 4'b0010, addr: 16'h0008, data: 32'h0, be: 4'h0, cyc: a + 1});
      step();
      t_rd_dvalid         = 4'b0010;
      t_rd_data[32 +: 32] = 32'h0BAD_F00D;
      rd_q.push_back('{data: 32'h0BAD_F00D, cyc: a + 3});
      step();
      t_rd_dvalid = 4'b0000;
      wait_idle();
      chk("t6_err_cnt", 64'(err_cnt), 64'd0);

      for (k = 0; k < 20; k++) begin
         if (rd_q.size() == 0 && wr_q.size() == 0 && rden_q.size() == 0) break;
         step();
      end
      repeat (2) step();
      chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
      chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
      chk("rden_q_drained", 64'(rden_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/avmm_csr_xbar_bridge.md
Name: avmm_csr_xbar_bridge

Overview:
Parametrised successor to the single-window JTAG-to-AVMM decoder. It takes one Avalon-MM master (JTAG master, mgmt side) and decodes it into NUM_TGT CSR target windows plus a local scratch register. It adds real waitrequest handshaking, per-byte enables, single-outstanding read tracking, a read timeout with error data, and a saturating error counter. It sits between the JTAG master and the per-channel CSR blocks in the same clk domain.

Parameters:
AW, 32, master address width
DW, 32, data width (multiple of 8)
LAW, 16, local (in-window) address width; window tag = address[AW-1:LAW]
NUM_TGT, 4, number of CSR target windows (1..16)
BASE_MAP, {16'h5003,16'h5002,16'h5001,16'h5000}, packed NUM_TGT x (AW-LAW) window tags; index 0 at LSBs
SCRATCH_ADDR, 32'h5000_0030, full address of local scratch register
TIMEOUT, 256, RD_WAIT cycles before error response (>=2)
ERR_DATA, 32'hDEAD_BEEF, readdata returned on miss/timeout

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
m_address  in  AW  master address
m_read  in  1  master read request
m_write  in  1  master write request
m_writedata  in  DW  master write data
m_byteenable  in  DW/8  master byte enables
m_readdata  out  DW  read response data
m_readdatavalid  out  1  read response strobe
m_waitrequest  out  1  master stall
t_addr  out  LAW  shared target local address
t_wr_data  out  DW  shared target write data
t_byteenable  out  DW/8  shared target byte enables
t_wr_en  out  NUM_TGT  one-hot write strobe
t_rd_en  out  NUM_TGT  one-hot read strobe
t_rd_data  in  NUM_TGT*DW  per-target read data, packed
t_rd_dvalid  in  NUM_TGT  per-target read data valid
err_cnt  out  8  saturating miss+timeout count

Behaviour:
- Reset (rst_n async, active-low; clock clk): all outputs 0 except m_waitrequest=1; state IDLE; scratch=0; err_cnt=0.
- FSM states: IDLE, ISSUE, RD_WAIT, RD_RESP.
- IDLE: m_waitrequest=0. A command is accepted when m_read|m_write is high. Register address, wdata, byteenable and type, then go to ISSUE. If both m_read and m_write are high, the write wins.
- All other states: m_waitrequest=1. One outstanding transaction at a time.
- Decode (from registered address):
  - Scratch hit (full address == SCRATCH_ADDR) has top priority.
  - Otherwise the lowest-index target whose BASE_MAP tag equals address[AW-1:LAW] is selected.
  - Otherwise the access is a miss.
- ISSUE (1 cycle): t_addr, t_wr_data and t_byteenable are driven from registers. They hold their values through RD_WAIT and are 0 in IDLE.
  - Write to target: t_wr_en[sel]=1 for this cycle only -> IDLE.
  - Write to scratch: update the bytes whose byteenable bit is set -> IDLE.
  - Write miss: dropped, err_cnt++ -> IDLE.
  - Read from target: t_rd_en[sel]=1 for this cycle only -> RD_WAIT.
  - Read from scratch: -> RD_RESP with data=scratch.
  - Read miss: -> RD_RESP with data=ERR_DATA, err_cnt++.
- RD_WAIT:
  - Wait counter starts at 0.
  - t_rd_dvalid[sel] high: capture the sel slice of t_rd_data -> RD_RESP.
  - Counter reaches TIMEOUT-1 without dvalid: data=ERR_DATA, err_cnt++ -> RD_RESP.
  - dvalid from a non-selected target is ignored.
  - dvalid arriving in the ISSUE cycle is ignored.
- RD_RESP: m_readdatavalid=1 and m_readdata=captured data, one cycle only -> IDLE. m_readdata is 0 when readdatavalid is low.
- Late dvalid from a timed-out target, arriving in IDLE or during a later transaction to a different target, is ignored.
- Latency:
  - Write: t_wr_en asserts 1 cycle after acceptance.
  - Scratch or miss read: readdatavalid asserts 2 cycles after acceptance.
  - Target read: readdatavalid asserts 1 cycle after t_rd_dvalid.
  - Minimum command spacing: 2 cycles for writes.
- err_cnt saturates at 8'hFF. Simultaneous events add at most 1 per cycle.
- Reset mid-transaction: the FSM aborts to IDLE, all strobes drop immediately, and no response is issued.

Decomposition:
- Shared package avmm_bridge_pkg:
  - FSM state enum
  - default ERR_DATA
  - default BASE_MAP and SCRATCH_ADDR constants
  - function for extracting a DW slice from packed t_rd_data
- Sub-module avmm_win_decode: combinational priority decoder, address -> {scratch_hit, tgt_onehot[NUM_TGT], miss}. Instantiated once; unit-testable alone.

Test Plan:
1. Write 32'h1234_5678 to 32'h5002_0010 with be=4'hF -> one-cycle t_wr_en=4'b0100, t_addr=16'h0010, t_wr_data=32'h1234_5678; err_cnt stays 0.
2. Read 32'h5001_0004; target 1 asserts dvalid 3 cycles after t_rd_en with data 32'hCAFE_0001 -> m_readdatavalid one cycle later with 32'hCAFE_0001; waitrequest high from the ISSUE cycle until the response.
3. Write 32'hAABB_CCDD to SCRATCH_ADDR with be=4'b0101, then read it back -> 32'h00BB_00DD, readdatavalid 2 cycles after read acceptance; no t_wr_en or t_rd_en pulses.
4. Read 32'h6000_0000 (miss) -> ERR_DATA 32'hDEAD_BEEF, t_rd_en stays 0, err_cnt=1.
5. Read target 3 and never assert dvalid -> ERR_DATA exactly TIMEOUT cycles after t_rd_en, err_cnt increments. A late dvalid from target 3 during a following target 0 read is ignored, and target 0's data is returned.
6. Assert rst_n low while in RD_WAIT -> immediately m_waitrequest=1 and all strobes 0; after release, no readdatavalid appears and the next read completes normally.
